seq_detector_prog: RTL and testbench

SEQ_DETECTOR_PROG -- requirements
Module: seq_detector_prog

---
 rtl/seq_detector_prog.sv | 80 ++++++++
 tb/tb_seq_detector_prog.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: zero-latency Mealy match pulse,
// overlap/non-overlap modes, saturating match counter.
module seq_detector_prog #(
  parameter int N     = 8,
  parameter int CNT_W = 8,
  parameter int LW    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pattern,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_err,
  output logic             enabled
);

  logic [N-1:0]  pat_r;
  logic [LW-1:0] len_r;
  logic          ovl_r;
  logic [N-2:0]  hist;
  logic [LW-1:0] fill;

  logic [N-1:0]  win;
  logic [N-1:0]  mask;
  logic          fill_ok;
  logic          pat_ok;

  assign enabled = (len_r != '0) && (int'(len_r) <= N);
  assign cfg_err = ~enabled;

  // Window is {history, current bit}; only the low len_r bits take part.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) mask[i] = (i < int'(len_r));
    win     = {hist, x};
    pat_ok  = ((win ^ pat_r) & mask) == '0;
    fill_ok = (int'(fill) + 1) >= int'(len_r);
    z       = x_valid & ~cfg_load & enabled & fill_ok & pat_ok;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_r <= '0;
      len_r <= '0;
      ovl_r <= 1'b0;
      hist  <= '0;
      fill  <= '0;
    end else if (cfg_load) begin
      pat_r <= cfg_pattern;
      len_r <= cfg_len;
      ovl_r <= cfg_overlap;
      fill  <= '0;
    end else if (x_valid && enabled) begin
      if (z && !ovl_r) begin
        fill <= '0;
      end else begin
        hist <= win[N-2:0];
        if (int'(fill) < N-1) fill <= fill + 1'b1;
      end
    end
  end

  // Clear takes priority, then the current detection is counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_count <= '0;
    end else if (cnt_clr) begin
      match_count <= {{(CNT_W-1){1'b0}}, z};
    end else if (z && match_count != '1) begin
      match_count <= match_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: directed scenarios plus randomized traffic
// against a queue-based reference model; a CNT_W=2 copy exercises saturation.
module tb_seq_detector_prog;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic x, x_valid, cfg_load, cfg_overlap, cnt_clr;
  logic [N-1:0] cfg_pattern;
  logic [3:0]   cfg_len;
  logic z, cfg_err, enabled;
  logic [7:0] match_count;
  logic z2, cfg_err2, enabled2;
  logic [1:0] match_count2;

  always #5 clk = ~clk;

  seq_detector_prog #(.N(N), .CNT_W(8), .LW(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z), .match_count(match_count), .cfg_err(cfg_err),
    .enabled(enabled));

  seq_detector_prog #(.N(N), .CNT_W(2), .LW(4)) u_sat (
    .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z2), .match_count(match_count2), .cfg_err(cfg_err2),
    .enabled(enabled2));

  int checks = 0;
  int errors = 0;

  // Reference model: accepted bits since the last discard, oldest first.
  bit [N-1:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         q[$];
  int         m_cnt;

  function automatic bit m_valid();
    return (m_len >= 1) && (m_len <= N);
  endfunction

  function automatic bit model_z();
    longint unsigned val, mask;
    if (!x_valid || cfg_load || !m_valid()) return 1'b0;
    if (q.size() < m_len - 1) return 1'b0;
    val = 0;
    for (int i = q.size() - (m_len - 1); i < q.size(); i++) val = (val << 1) | longint'(q[i]);
    val  = (val << 1) | longint'(x);
    mask = (64'd1 << m_len) - 1;
    return val == (longint'(m_pat) & mask);
  endfunction

  function automatic int exp_cnt(int maxv);
    return (m_cnt > maxv) ? maxv : m_cnt;
  endfunction

  function automatic void model_reset();
    m_pat = '0; m_len = 0; m_ovl = 0; q.delete(); m_cnt = 0;
  endfunction

  // Advance one clock from a negedge to the next, updating the model.
  task automatic tick();
    bit zz;
    zz = model_z();
    @(posedge clk);
    if (cfg_load) begin
      m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap; q.delete();
    end else if (x_valid && m_valid()) begin
      if (zz && !m_ovl) q.delete();
      else begin
        q.push_back(x);
        if (q.size() > N - 1) void'(q.pop_front());
      end
    end
    if (cnt_clr) m_cnt = zz ? 1 : 0;
    else if (zz) m_cnt++;
    @(negedge clk);
  endtask

  task automatic set_in(input bit v, input bit b);
    x_valid = v; x = b; cfg_load = 0; cnt_clr = 0;
  endtask

  task automatic load(input logic [N-1:0] pat, input logic [3:0] len, input bit ovl, input bit clr);
    cfg_load = 1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cnt_clr = clr;
    x_valid = 1; x = 1'($urandom);
    tick();
    cfg_load = 0; cnt_clr = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (z !== 1'b0 || match_count !== 8'd0 || enabled !== 1'b0 || cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: z=%b cnt=%0d en=%b err=%b, want 0 0 0 1", z, match_count, enabled, cfg_err);
    end
    @(negedge clk);
    reset_n = 1;
    // Unconfigured after reset: no detection on any stream.
    for (int i = 0; i < 6; i++) begin
      set_in(1, 1'($urandom)); #1;
      checks++;
      if (z !== 1'b0) begin errors++; $display("FAIL noload_z: bit %0d z=%b want 0", i, z); end
      tick();
    end
  endtask

  task automatic run_1011(input bit ovl, input string nm, input bit [6:0] ez, input int ecnt);
    bit [6:0] s;
    s = 7'b1011011;
    load({4'($urandom), 4'b1011}, 4'd4, ovl, 1);
    for (int i = 0; i < 7; i++) begin
      set_in(1, s[6-i]); #1;
      checks++;
      if (z !== ez[6-i]) begin errors++; $display("FAIL %s_z: bit %0d z=%b want %b", nm, i+1, z, ez[6-i]); end
      tick();
    end
    #1;
    checks++;
    if (match_count !== 8'(ecnt)) begin
      errors++; $display("FAIL %s_cnt: count=%0d want %0d", nm, match_count, ecnt);
    end
  endtask

  task automatic test_non_overlap();
    run_1011(0, "nonovl", 7'b0001000, 1);
  endtask

  task automatic test_overlap();
    run_1011(1, "ovl", 7'b0001001, 2);
  endtask

  task automatic test_gaps_reconfig();
    bit [3:0] s;
    bit [7:0] a5;
    load({4'($urandom), 4'b1011}, 4'd4, 1, 1);
    s = 4'b1011;
    for (int i = 0; i < 7; i++) begin
      if (i < 2)      set_in(1, s[3-i]);
      else if (i < 5) set_in(0, 1'($urandom));
      else            set_in(1, s[3-(i-3)]);
      #1;
      checks++;
      if (z !== (i == 6)) begin errors++; $display("FAIL gap_z: step %0d z=%b want %b", i, z, (i == 6)); end
      tick();
    end
    set_in(1, 1); tick();
    set_in(1, 0); tick();
    cfg_load = 1; cfg_pattern = 8'hA5; cfg_len = 4'd8; cfg_overlap = 0; x_valid = 1; x = 1; #1;
    checks++;
    if (z !== 1'b0) begin errors++; $display("FAIL load_z: z=%b want 0", z); end
    tick();
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      set_in(1, a5[7-i]); #1;
      checks++;
      if (z !== (i == 7)) begin errors++; $display("FAIL a5_z: bit %0d z=%b want %b", i+1, z, (i == 7)); end
      tick();
    end
  endtask

  task automatic test_invalid_len();
    int c0;
    #1; c0 = int'(match_count);
    for (int k = 0; k < 2; k++) begin
      load(8'hFF, (k == 0) ? 4'd0 : 4'd9, 1'($urandom), 0);
      #1;
      checks++;
      if (cfg_err !== 1'b1 || enabled !== 1'b0) begin
        errors++; $display("FAIL badlen_flags: len case %0d err=%b en=%b want 1 0", k, cfg_err, enabled);
      end
      for (int i = 0; i < 12; i++) begin
        set_in(1, (i < 6) ? 1'b1 : 1'($urandom)); #1;
        checks++;
        if (z !== 1'b0) begin errors++; $display("FAIL badlen_z: case %0d bit %0d z=%b want 0", k, i, z); end
        tick();
      end
    end
    #1;
    checks++;
    if (int'(match_count) !== c0) begin
      errors++; $display("FAIL badlen_cnt: count=%0d want %0d", match_count, c0);
    end
  endtask

  task automatic test_counter();
    load(8'h01, 4'd1, 1, 1);
    for (int i = 0; i < 5; i++) begin set_in(1, 1); tick(); end
    #1;
    checks++;
    if (match_count2 !== 2'd3 || match_count !== 8'd5) begin
      errors++; $display("FAIL sat_cnt: cnt2=%0d cnt8=%0d want 3 5", match_count2, match_count);
    end
    set_in(1, 1); cnt_clr = 1; tick();
    #1;
    checks++;
    if (match_count2 !== 2'd1 || match_count !== 8'd1) begin
      errors++; $display("FAIL clr_with_z: cnt2=%0d cnt8=%0d want 1 1", match_count2, match_count);
    end
    set_in(1, 0); cnt_clr = 1; tick();
    #1;
    checks++;
    if (match_count !== 8'd0) begin errors++; $display("FAIL clr_no_z: cnt=%0d want 0", match_count); end
  endtask

  task automatic test_reset_mid();
    bit [2:0] s;
    load({4'($urandom), 4'b1011}, 4'd4, 0, 0);
    s = 3'b101;
    for (int i = 0; i < 3; i++) begin set_in(1, s[2-i]); tick(); end
    set_in(1, 1);
    #2 reset_n = 0; model_reset();
    #1;
    checks++;
    if (z !== 1'b0 || match_count !== 8'd0 || enabled !== 1'b0) begin
      errors++; $display("FAIL midreset: z=%b cnt=%0d en=%b want 0 0 0", z, match_count, enabled);
    end
    @(negedge clk);
    reset_n = 1;
    load({4'($urandom), 4'b1011}, 4'd4, 0, 0);
    set_in(1, 1); #1;
    checks++;
    if (z !== 1'b0) begin errors++; $display("FAIL post_reset_z: z=%b want 0", z); end
    tick();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      x_valid = ($urandom_range(0, 3) != 0);
      x       = 1'($urandom);
      cnt_clr = ($urandom_range(0, 19) == 0);
      cfg_load = (cyc % 60 == 0) || ($urandom_range(0, 49) == 0);
      if (cfg_load) begin
        cfg_pattern = N'($urandom);
        cfg_overlap = 1'($urandom);
        case ($urandom_range(0, 9))
          0:       cfg_len = 4'($urandom_range(0, 1) ? 9 : 0);
          1, 2:    cfg_len = 4'($urandom_range(5, 8));
          default: cfg_len = 4'($urandom_range(1, 4));
        endcase
      end
      #1;
      checks++;
      if (z !== model_z() || z2 !== model_z() || enabled !== m_valid() || cfg_err !== !m_valid()
          || enabled2 !== m_valid() || int'(match_count) !== exp_cnt(255)
          || int'(match_count2) !== exp_cnt(3)) begin
        errors++;
        $display("FAIL rand: cyc %0d z=%b/%b cnt=%0d/%0d en=%b want z=%b cnt=%0d/%0d en=%b",
                 cyc, z, z2, match_count, match_count2, enabled, model_z(), exp_cnt(255), exp_cnt(3), m_valid());
      end
      tick();
    end
  endtask

  initial begin
    reset_n = 0; x = 0; x_valid = 0; cfg_load = 0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 0; cnt_clr = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_non_overlap();
    test_overlap();
    test_gaps_reconfig();
    test_invalid_len();
    test_counter();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
